// File: rtl/gf8_pow_sequencer.sv
// GF(2^3) exponentiation engine, P(x) = x^3 + x^2 + 1.
// Computes result = base^exp by left-to-right square-and-multiply.
// A single combinational multiplier is shared between the square and
// multiply steps, so each step takes one clock cycle.

// Combinational Mastrovito multiplier for GF(2^3) with P(x) = x^3 + x^2 + 1.
module mastrovito_multiplier (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] p
);

  logic [4:0] s_s;

  // Carry-less product, then fold x^3 = x^2 + 1 and x^4 = x^2 + x + 1 back in.
  always_comb begin
    s_s = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s_s[i+j] = s_s[i+j] ^ (a[i] & b[j]);
      end
    end
    p[0] = s_s[0] ^ s_s[3] ^ s_s[4];
    p[1] = s_s[1] ^ s_s[4];
    p[2] = s_s[2] ^ s_s[3] ^ s_s[4];
  end

endmodule

module gf8_pow_sequencer #(
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       base,
  input  logic [EXP_W-1:0] exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       result,
  output logic             busy
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SQR  = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       base_r;
  logic [EXP_W-1:0] exp_r;
  logic [2:0]       acc_r, acc_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic             load_s;
  logic [2:0]       op_b_s;
  logic [2:0]       prod_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [2:0]       result_r;

  // Second multiplier operand: base only while multiplying, otherwise squaring.
  always_comb begin
    if (state_r == ST_MUL) begin
      op_b_s = base_r;
    end else begin
      op_b_s = acc_r;
    end
  end

  mastrovito_multiplier u_mul (
    .a (acc_r),
    .b (op_b_s),
    .p (prod_s)
  );

  // Next-state, accumulator and bit-index sequencing.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    idx_nxt_s   = idx_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          load_s      = 1'b1;
          acc_nxt_s   = 3'b001;
          idx_nxt_s   = IDX_MAX;
          state_nxt_s = ST_SQR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SQR: begin
        acc_nxt_s = prod_s;
        if (exp_r[idx_r]) begin
          state_nxt_s = ST_MUL;
        end else if (idx_r == IDX_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          idx_nxt_s   = idx_r - IDX_W'(1);
          state_nxt_s = ST_SQR;
        end
      end
      ST_MUL: begin
        acc_nxt_s = prod_s;
        if (idx_r == IDX_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          idx_nxt_s   = idx_r - IDX_W'(1);
          state_nxt_s = ST_SQR;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, operand and registered output update; rst aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      base_r      <= 3'b000;
      exp_r       <= {EXP_W{1'b0}};
      acc_r       <= 3'b001;
      idx_r       <= IDX_MAX;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= 3'b001;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      idx_r       <= idx_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      result_r    <= acc_nxt_s;
      if (load_s) begin
        base_r <= base;
        exp_r  <= exp;
      end else begin
        base_r <= base_r;
        exp_r  <= exp_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;

endmodule

// File: tb/tb_gf8_pow_sequencer.sv
// Self-checking bench for gf8_pow_sequencer: directed vectors, backpressure,
// mid-operation reset and an exhaustive sweep against a reference model.
module tb_gf8_pow_sequencer;

  localparam int EXP_W = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       base;
  logic [EXP_W-1:0] exp;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       result;
  logic             busy;

  int checks_r;
  int failures_r;

  gf8_pow_sequencer #(.EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base      (base),
    .exp       (exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_r++;
    if (got !== want) begin
      failures_r++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference multiply by shift-and-add with x^3 = x^2 + 1.
  function automatic logic [2:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    logic [2:0] t;
    r = 3'b000;
    t = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) r = r ^ t;
      t = t[2] ? ({t[1:0], 1'b0} ^ 3'b101) : {t[1:0], 1'b0};
    end
    return r;
  endfunction

  // Reference power by repeated multiplication (0^0 = 1).
  function automatic logic [2:0] ref_pow(input logic [2:0] b, input int e);
    logic [2:0] r;
    r = 3'b001;
    for (int i = 0; i < e; i++) r = ref_mul(r, b);
    return r;
  endfunction

  // One full transaction, entered and left on a negative edge.
  task automatic run_op(input logic [2:0] b, input logic [EXP_W-1:0] e,
                        input logic [2:0] want, input int hold, input bit noise);
    int  lat;
    int  n_exp;
    bit  bad;
    n_exp = EXP_W + $countones(e);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_val("in_ready_before_accept", 32'(in_ready), 32'd1);
    base     = b;
    exp      = e;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) bad = 1'b1;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        base     = 3'($urandom);
        exp      = EXP_W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_val("busy_no_ready_while_running", 32'(bad), 32'd0);
    check_val("latency", 32'(lat), 32'(n_exp));
    check_val("result", 32'(result), 32'(want));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_result", 32'(result), 32'(want));
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("handoff_valid_low", 32'(out_valid), 32'd0);
    check_val("handoff_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    base       = 3'b000;
    exp        = '0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_result", 32'(result), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // out_ready while idle must not do anything.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("idle_out_ready_valid", 32'(out_valid), 32'd0);
    check_val("idle_out_ready_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-computed results.
    run_op(3'b010, 3'd3, 3'b101, 0, 1'b0);
    run_op(3'b010, 3'd6, 3'b110, 0, 1'b0);
    run_op(3'b011, 3'd6, 3'b100, 0, 1'b0);
    run_op(3'b111, 3'd7, 3'b001, 0, 1'b0);
    run_op(3'b000, 3'd0, 3'b001, 0, 1'b0);
    run_op(3'b000, 3'd6, 3'b000, 0, 1'b0);
    run_op(3'b101, 3'd0, 3'b001, 0, 1'b0);

    // Backpressure, then an immediate follow-up operand.
    run_op(3'b010, 3'd5, 3'b011, 4, 1'b0);
    run_op(3'b010, 3'd4, 3'b111, 0, 1'b0);

    // Reset during the second op cycle (MUL, since exp bit 2 is set).
    base     = 3'b110;
    exp      = 3'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    check_val("midrst_result", 32'(result), 32'd1);
    check_val("midrst_busy", 32'(busy), 32'd0);
    run_op(3'b010, 3'd4, 3'b111, 0, 1'b0);

    // Exhaustive sweep with random in_valid noise while busy.
    for (int b = 0; b < 8; b++) begin
      for (int e = 0; e < (1 << EXP_W); e++) begin
        run_op(3'(b), EXP_W'(e), ref_pow(3'(b), e), (b + e) % 2, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
